miner_work_ctrl: RTL and testbench

MINER_WORK_CTRL -- requirements
Module: miner_work_ctrl

---
 rtl/miner_work_ctrl.sv | 135 +++++++++++++
 tb/tb_miner_work_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/miner_work_ctrl.sv
// miner_work_ctrl: feeds nonce ranges into an unrolled SHA-256 hasher and queues golden nonces.
// Optional MINER_SHARE_MASK_EN adds a share_mask input so a hit means (hash_top & share_mask) == 0.
module miner_work_ctrl #(
   parameter int LOOP_LOG2 = 0,
   parameter int PIPE_LAT  = 130,
   parameter int GN_DEPTH  = 4
) (
   input  logic         hash_clk,
   input  logic         reset_n,
   input  logic         work_valid,
   output logic         work_ready,
   input  logic [255:0] work_midstate,
   input  logic [95:0]  work_data,
   input  logic [31:0]  work_nonce_start,
   input  logic [31:0]  work_nonce_end,
   input  logic         abort,
   output logic [5:0]   cnt,
   output logic         feedback,
   output logic [255:0] hs_state,
   output logic [511:0] hs_data,
   input  logic [31:0]  hash_top,
`ifdef MINER_SHARE_MASK_EN
   input  logic [31:0]  share_mask,
`endif
   output logic         gn_valid,
   input  logic         gn_ready,
   output logic [31:0]  gn_nonce,
   output logic         busy,
   output logic         done,
   output logic         gn_overflow,
   output logic [31:0]  cur_nonce
);
   localparam int LOOP = 1 << LOOP_LOG2;
   localparam logic [5:0] CNT_MAX = 6'(LOOP - 1);
   localparam int AW = $clog2(GN_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_n;

   logic armed, last_q;
   logic [255:0] mid_q;
   logic [95:0] data_q;
   logic [31:0] end_q, nonce, ev;
   logic [PIPE_LAT-1:0] sr;
   logic [31:0] mem [GN_DEPTH];
   logic [AW:0] wp, rp;
   logic accept, kill, slot, last_slot, last_wrap, sample, hit, fin, full, push, pop;

   assign busy       = state != IDLE;
   assign work_ready = armed && state == IDLE;
   assign accept     = work_valid && work_ready;
   assign kill       = abort && busy;
   assign slot       = state == RUN && cnt == 6'd0 && !abort;
   assign last_slot  = slot && nonce == end_q;
   // stay in RUN until the last slot's unrolled rounds have been clocked through
   assign last_wrap  = cnt == CNT_MAX && (last_q || last_slot);
   // each issue slot travels PIPE_LAT cycles down sr to become its sample point
   assign sample     = sr[PIPE_LAT-1] && !kill;
`ifdef MINER_SHARE_MASK_EN
   assign hit        = (hash_top & share_mask) == 32'd0;
`else
   assign hit        = hash_top == 32'd0;
`endif
   assign fin        = sample && ev == end_q;
   assign feedback   = cnt != 6'd0;
   assign full       = (wp ^ rp) == {1'b1, {AW{1'b0}}};
   assign gn_valid   = wp != rp;
   assign pop        = gn_valid && gn_ready;
   assign push       = sample && hit && (!full || pop);
   assign gn_nonce   = gn_valid ? mem[rp[AW-1:0]] : 32'd0;

   always_comb begin
      state_n = state;
      if (state == IDLE) state_n = accept ? RUN : IDLE;
      else if (kill || fin) state_n = IDLE;
      else if (state == RUN && last_wrap) state_n = DRAIN;
   end

   always_ff @(posedge hash_clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         armed <= 1'b0;
      end else begin
         state <= state_n;
         armed <= 1'b1;
      end
   end

   always_ff @(posedge hash_clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt         <= 6'd0;
         hs_state    <= '0;
         hs_data     <= '0;
         cur_nonce   <= 32'd0;
         done        <= 1'b0;
         gn_overflow <= 1'b0;
         wp          <= '0;
         rp          <= '0;
         sr          <= '0;
         nonce       <= 32'd0;
         ev          <= 32'd0;
         end_q       <= 32'd0;
         mid_q       <= '0;
         data_q      <= '0;
         last_q      <= 1'b0;
      end else begin
         cnt  <= (state == RUN && state_n == RUN && cnt != CNT_MAX) ? cnt + 6'd1 : 6'd0;
         done <= fin;
         sr   <= kill ? '0 : (sr << 1) | PIPE_LAT'(slot);
         if (sample) ev <= ev + 32'd1;
         if (push) wp <= wp + (AW+1)'(1);
         if (pop) rp <= rp + (AW+1)'(1);
         if (sample && hit && full && !pop) gn_overflow <= 1'b1;
         if (accept) begin
            mid_q  <= work_midstate;
            data_q <= work_data;
            end_q  <= work_nonce_end;
            nonce  <= work_nonce_start;
            ev     <= work_nonce_start;
            last_q <= 1'b0;
         end
         if (slot) begin
            hs_state  <= mid_q;
            hs_data   <= {32'h0000_0280, 320'd0, 32'h8000_0000, nonce, data_q};
            cur_nonce <= nonce;
            nonce     <= nonce + 32'd1;
            if (last_slot) last_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge hash_clk) begin
      if (push) mem[wp[AW-1:0]] <= ev;
   end
endmodule

// File: tb/tb_miner_work_ctrl.sv
// tb_miner_work_ctrl: directed scoreboard bench; a monitor pops expected golden nonces as the DUT emits them.
module tb_miner_work_ctrl;
   localparam int PL = 10;

   logic hash_clk = 1'b0;
   logic reset_n, wv0, wv2, abort0, gn_ready0, gn_ready2, all_hit;
   logic [255:0] mid;
   logic [95:0] wdata;
   logic [31:0] ns, ne, share_mask, hit_val, hash_top0, hash_top2;
   int hit_at = -1, tcnt = 0, done_cnt0 = 0, done_cnt2 = 0, total = 0, passed = 0;
   logic [31:0] sb [$];

   logic wr0, fb0, gv0, busy0, done0, ovf0, wr2, fb2, gv2, busy2, done2, ovf2;
   logic [5:0] cnt0, cnt2;
   logic [255:0] hs_state0, hs_state2;
   logic [511:0] hs_data0, hs_data2;
   logic [31:0] gn0, cur0, gn2, cur2;

   always #5 hash_clk = ~hash_clk;

   // hasher model: hash_top is a hit only at the chosen cycle after the accept edge (or always)
   always @(posedge hash_clk) tcnt <= (wv0 && wr0) ? 0 : tcnt + 1;
   assign hash_top0 = (all_hit || tcnt == hit_at) ? hit_val : 32'hFFFF_FFFF;
   assign hash_top2 = 32'hFFFF_FFFF;

   miner_work_ctrl #(.LOOP_LOG2(0), .PIPE_LAT(PL), .GN_DEPTH(4)) dut0 (
      .hash_clk(hash_clk), .reset_n(reset_n), .work_valid(wv0), .work_ready(wr0),
      .work_midstate(mid), .work_data(wdata), .work_nonce_start(ns), .work_nonce_end(ne),
      .abort(abort0), .cnt(cnt0), .feedback(fb0), .hs_state(hs_state0), .hs_data(hs_data0),
      .hash_top(hash_top0),
`ifdef MINER_SHARE_MASK_EN
      .share_mask(share_mask),
`endif
      .gn_valid(gv0), .gn_ready(gn_ready0), .gn_nonce(gn0), .busy(busy0), .done(done0),
      .gn_overflow(ovf0), .cur_nonce(cur0));

   miner_work_ctrl #(.LOOP_LOG2(2), .PIPE_LAT(PL), .GN_DEPTH(4)) dut2 (
      .hash_clk(hash_clk), .reset_n(reset_n), .work_valid(wv2), .work_ready(wr2),
      .work_midstate(mid), .work_data(wdata), .work_nonce_start(ns), .work_nonce_end(ne),
      .abort(1'b0), .cnt(cnt2), .feedback(fb2), .hs_state(hs_state2), .hs_data(hs_data2),
      .hash_top(hash_top2),
`ifdef MINER_SHARE_MASK_EN
      .share_mask(share_mask),
`endif
      .gn_valid(gv2), .gn_ready(gn_ready2), .gn_nonce(gn2), .busy(busy2), .done(done2),
      .gn_overflow(ovf2), .cur_nonce(cur2));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h required %h", nm, act, exp);
   endtask

   always @(negedge hash_clk) begin
      if (reset_n) begin
         if (done0) done_cnt0++;
         if (done2) done_cnt2++;
         if (gv0 && gn_ready0) begin
            if (sb.size() == 0) begin
               total++;
               $display("FAIL gn_unexpected: got %h required no nonce", gn0);
            end else chk("gn_nonce", {32'd0, gn0}, {32'd0, sb.pop_front()});
         end
      end
   end

   task automatic send(input bit two, input logic [31:0] s, input logic [31:0] e);
      ns = s;
      ne = e;
      if (two) wv2 = 1'b1; else wv0 = 1'b1;
      @(posedge hash_clk); #1;
      wv0 = 1'b0;
      wv2 = 1'b0;
   endtask

   task automatic wait_done(input bit two, input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge hash_clk);
         seen = two ? done2 : done0;
      end
      chk(nm, {63'd0, seen}, 64'd1);
      @(posedge hash_clk); #1;
   endtask

   initial begin
      int dc;
      reset_n = 1'b1; wv0 = 1'b0; wv2 = 1'b0; abort0 = 1'b0; gn_ready0 = 1'b1; gn_ready2 = 1'b1;
      all_hit = 1'b0; hit_val = 32'd0; share_mask = 32'hFFFF_FFFF;
      mid = {8{32'hDEAD_BEEF}}; wdata = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333}; ns = 0; ne = 0;
      #2 reset_n = 1'b0;
      repeat (2) @(posedge hash_clk); #1;
      chk("rst_work_ready", {63'd0, wr0}, 0);
      chk("rst_busy", {63'd0, busy0}, 0);
      chk("rst_gn_valid", {63'd0, gv0}, 0);
      chk("rst_cnt_fb", {57'd0, cnt0, fb0}, 0);
      chk("rst_hs", {62'd0, hs_data0 == '0, hs_state0 == '0}, 3);
      chk("rst_cur_ovf_done", {cur0, 30'd0, ovf0, done0}, 0);
      reset_n = 1'b1;
      chk("ready_before_edge", {63'd0, wr0}, 0);
      @(posedge hash_clk); #1;
      chk("ready_after_edge", {63'd0, wr0}, 1);

      // single hit at sample k=2 of range 0x10..0x13
      sb.push_back(32'h12);
      hit_at = PL + 2;
      send(0, 32'h10, 32'h13);
      wait_done(0, "done_basic");
      hit_at = -1;
      chk("idle_basic", {62'd0, busy0, wr0}, 1);
      chk("cur_basic", {32'd0, cur0}, 64'h13);
      chk("hs_state_basic", {63'd0, hs_state0 == mid}, 1);
      chk("hs_data_basic", {63'd0, hs_data0 == {32'h280, 320'd0, 32'h8000_0000, 32'h13, wdata}}, 1);
      chk("ovf_basic", {63'd0, ovf0}, 0);

      // wrapping range fills the FIFO exactly
      gn_ready0 = 1'b0;
      all_hit = 1'b1;
      send(0, 32'hFFFF_FFFE, 32'h1);
      wait_done(0, "done_wrap");
      chk("wrap_head", {31'd0, gv0, gn0}, {31'd0, 1'b1, 32'hFFFF_FFFE});
      chk("wrap_ovf", {63'd0, ovf0}, 0);
      sb.push_back(32'hFFFF_FFFE); sb.push_back(32'hFFFF_FFFF); sb.push_back(32'h0); sb.push_back(32'h1);
      gn_ready0 = 1'b1;
      repeat (6) @(posedge hash_clk); #1;
      chk("wrap_drained", {31'd0, gv0, sb.size()}, 0);
      all_hit = 1'b0;

      // unrolled instance: cnt/feedback sequence and issued nonce
      send(1, 32'h0, 32'h1);
      for (int i = 0; i < 8; i++) begin
         @(negedge hash_clk);
         chk("loop_cnt", {58'd0, cnt2}, 64'(i % 4));
         chk("loop_fb", {63'd0, fb2}, {63'd0, i % 4 != 0});
         if (i == 1) chk("loop_nonce0", {32'd0, hs_data2[127:96]}, 0);
         if (i == 5) chk("loop_nonce1", {32'd0, hs_data2[127:96]}, 1);
      end
      @(negedge hash_clk);
      chk("loop_drain", {56'd0, cnt2, fb2, busy2}, 1);
      wait_done(1, "done_loop");
      chk("loop_quiet", {30'd0, gv2, ovf2, gn2}, 0);
      chk("loop_end", {cur2, 31'd0, hs_state2 == mid}, {32'h1, 32'h1});

      // abort mid-run: no done, no pushes
      all_hit = 1'b1;
      dc = done_cnt0;
      send(0, 32'h100, 32'h1FF);
      repeat (4) @(posedge hash_clk); #1;
      abort0 = 1'b1;
      @(posedge hash_clk); #1;
      abort0 = 1'b0;
      chk("abort_idle", {62'd0, busy0, wr0}, 1);
      repeat (30) @(posedge hash_clk); #1;
      chk("abort_no_done", 64'(done_cnt0), 64'(dc));
      chk("abort_no_push", {63'd0, gv0}, 0);
      all_hit = 1'b0;
      abort0 = 1'b1;
      send(0, 32'h0, 32'hA);
      chk("abort_with_work", {63'd0, busy0}, 1);
      @(posedge hash_clk); #1;
      abort0 = 1'b0;
      chk("abort_again", {63'd0, busy0}, 0);

      // hash_top = 0x0000ABCD: hit only through a share mask
      all_hit = 1'b1;
      hit_val = 32'h0000_ABCD;
`ifdef MINER_SHARE_MASK_EN
      share_mask = 32'hFFFF_0000;
      sb.push_back(32'h5);
`endif
      send(0, 32'h5, 32'h5);
      wait_done(0, "done_mask");
      repeat (3) @(posedge hash_clk); #1;
      chk("mask_result", {31'd0, gv0, sb.size()}, 0);
      share_mask = 32'hFFFF_FFFF;
      hit_val = 32'd0;

      // fifth nonce dropped on full FIFO
      gn_ready0 = 1'b0;
      send(0, 32'hFFFF_FFFE, 32'h2);
      wait_done(0, "done_ovf");
      chk("ovf_set", {62'd0, ovf0, gv0}, 3);
      sb.push_back(32'hFFFF_FFFE); sb.push_back(32'hFFFF_FFFF); sb.push_back(32'h0); sb.push_back(32'h1);
      gn_ready0 = 1'b1;
      repeat (6) @(posedge hash_clk); #1;
      chk("ovf_drained", {31'd0, gv0, sb.size()}, 0);
      chk("ovf_sticky", {63'd0, ovf0}, 1);
      all_hit = 1'b0;

      // asynchronous reset in RUN discards the work
      send(0, 32'h0, 32'd1000);
      repeat (5) @(posedge hash_clk); #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst", {cur0, 29'd0, busy0, ovf0, wr0}, 0);
      chk("async_rst_hs", {63'd0, hs_data0 == '0}, 1);
      @(posedge hash_clk); #1;
      reset_n = 1'b1;
      dc = done_cnt0;
      repeat (PL + 20) @(posedge hash_clk); #1;
      chk("rst_no_done", 64'(done_cnt0), 64'(dc));
      chk("rst_idle", {62'd0, busy0, wr0}, 1);
      chk("sb_empty", 64'(sb.size()), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
